// File: rtl/asrv32_alu_arbiter.sv
// Two-requester front end for a single shared asrv32_alu.
// One op in flight at a time; results return on a tagged, stallable channel.
module asrv32_alu #(
  parameter int ALU_WIDTH = 14
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alu_en,
  input  logic [ALU_WIDTH-1:0] i_alu,
  input  logic [31:0]          i_op1,
  input  logic [31:0]          i_op2,
  output logic [31:0]          o_y
);
  localparam int ADD  = 0;
  localparam int SUB  = 1;
  localparam int SLT  = 2;
  localparam int SLTU = 3;
  localparam int XOR  = 4;
  localparam int OR   = 5;
  localparam int AND  = 6;
  localparam int SLL  = 7;
  localparam int SRL  = 8;
  localparam int SRA  = 9;
  localparam int EQ   = 10;
  localparam int NEQ  = 11;
  localparam int GE   = 12;
  localparam int GEU  = 13;

  logic [31:0] y;
  logic [4:0]  sh;

  assign sh = i_op2[4:0];

  always_comb begin
    y = '0;
    unique case (1'b1)
      i_alu[ADD]:  y = i_op1 + i_op2;
      i_alu[SUB]:  y = i_op1 - i_op2;
      i_alu[SLT]:  y = {31'd0, $signed(i_op1) < $signed(i_op2)};
      i_alu[SLTU]: y = {31'd0, i_op1 < i_op2};
      i_alu[XOR]:  y = i_op1 ^ i_op2;
      i_alu[OR]:   y = i_op1 | i_op2;
      i_alu[AND]:  y = i_op1 & i_op2;
      i_alu[SLL]:  y = i_op1 << sh;
      i_alu[SRL]:  y = i_op1 >> sh;
      i_alu[SRA]:  y = $unsigned($signed(i_op1) >>> sh);
      i_alu[EQ]:   y = {31'd0, i_op1 == i_op2};
      i_alu[NEQ]:  y = {31'd0, i_op1 != i_op2};
      i_alu[GE]:   y = {31'd0, $signed(i_op1) >= $signed(i_op2)};
      i_alu[GEU]:  y = {31'd0, i_op1 >= i_op2};
      default:     y = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      o_y <= '0;
    else if (i_alu_en)
      o_y <= y;
  end
endmodule

module asrv32_alu_arbiter #(
  parameter int ALU_WIDTH = 14,
  parameter int FAIR      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [ALU_WIDTH-1:0] i_req0_alu,
  input  logic [31:0]          i_req0_op1,
  input  logic [31:0]          i_req0_op2,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [ALU_WIDTH-1:0] i_req1_alu,
  input  logic [31:0]          i_req1_op1,
  input  logic [31:0]          i_req1_op2,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_rsp_id,
  output logic [31:0]          o_rsp_result,
  output logic                 o_busy
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state, state_n;

  logic                 prio_q;
  logic                 id_q;
  logic [ALU_WIDTH-1:0] op_q;
  logic [31:0]          op1_q;
  logic [31:0]          op2_q;

  logic grant0, grant1;
  logic accept;
  logic alu_en;
  logic rsp_valid;
  logic [31:0] alu_y;

  // prio_q only breaks ties; a lone requester always wins
  assign grant1 = i_req1_valid &
                  (~i_req0_valid | ((FAIR != 0) & prio_q));
  assign grant0 = i_req0_valid & ~grant1;

  always_comb begin
    state_n      = state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    accept       = 1'b0;
    alu_en       = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_req0_ready = grant0 & ~i_rst;
        o_req1_ready = grant1 & ~i_rst;
        accept       = grant0 | grant1;
        if (accept)
          state_n = ISSUE;
      end
      ISSUE: begin
        alu_en  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (i_rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      prio_q <= 1'b0;
      id_q   <= 1'b0;
      op_q   <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        id_q  <= grant1;
        op_q  <= grant1 ? i_req1_alu : i_req0_alu;
        op1_q <= grant1 ? i_req1_op1 : i_req0_op1;
        op2_q <= grant1 ? i_req1_op2 : i_req0_op2;
        if (FAIR != 0)
          prio_q <= ~grant1;
      end
    end
  end

  asrv32_alu #(
    .ALU_WIDTH(ALU_WIDTH)
  ) u_alu (
    .i_clk    (i_clk),
    .i_rst_n  (~i_rst),
    .i_alu_en (alu_en),
    .i_alu    (op_q),
    .i_op1    (op1_q),
    .i_op2    (op2_q),
    .o_y      (alu_y)
  );

  assign o_rsp_valid  = rsp_valid & ~i_rst;
  assign o_rsp_id     = o_rsp_valid & id_q;
  assign o_rsp_result = o_rsp_valid ? alu_y : 32'd0;
  assign o_busy       = (state != IDLE);
endmodule

// File: tb/tb_asrv32_alu_arbiter.sv
// Directed + randomized checks of the shared ALU arbiter.
// A fair instance carries most traffic; a fixed-priority one checks starvation.
module tb_asrv32_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        r0, r1;
  logic [13:0] alu0 = '0, alu1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;

  logic        fv0 = 1'b0, fv1 = 1'b0;
  logic        fr0, fr1;
  logic [13:0] falu0 = '0, falu1 = '0;
  logic [31:0] fa0 = '0, fb0 = '0, fa1 = '0, fb1 = '0;
  logic        frsp_valid, frsp_id, fbusy;
  logic        frsp_ready = 1'b1;
  logic [31:0] frsp_result;

  int vectors = 0;
  int miscompares = 0;
  int exp_prio = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  asrv32_alu_arbiter #(.ALU_WIDTH(14), .FAIR(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_alu(alu0),
    .i_req0_op1(a0), .i_req0_op2(b0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_alu(alu1),
    .i_req1_op1(a1), .i_req1_op2(b1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_result(rsp_result), .o_busy(busy)
  );

  asrv32_alu_arbiter #(.ALU_WIDTH(14), .FAIR(0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(fv0), .o_req0_ready(fr0), .i_req0_alu(falu0),
    .i_req0_op1(fa0), .i_req0_op2(fb0),
    .i_req1_valid(fv1), .o_req1_ready(fr1), .i_req1_alu(falu1),
    .i_req1_op1(fa1), .i_req1_op2(fb1),
    .o_rsp_valid(frsp_valid), .i_rsp_ready(frsp_ready),
    .o_rsp_id(frsp_id), .o_rsp_result(frsp_result), .o_busy(fbusy)
  );

  // op index: 0 ADD 1 SUB 2 SLT 3 SLTU 4 XOR 5 OR 6 AND 7 SLL
  //           8 SRL 9 SRA 10 EQ 11 NEQ 12 GE 13 GEU
  function automatic logic [31:0] ref_alu(logic [13:0] op,
                                          logic [31:0] a, logic [31:0] b);
    int k = -1;
    int sa, sb;
    int sh;
    for (int i = 0; i < 14; i++)
      if (op[i]) k = i;
    sa = a;
    sb = b;
    sh = int'(b % 32);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 1 : 0;
      3:  return (a < b) ? 1 : 0;
      4:  return a ^ b;
      5:  return a | b;
      6:  return a & b;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return $unsigned(sa >>> sh);
      10: return (a == b) ? 1 : 0;
      11: return (a != b) ? 1 : 0;
      12: return (sa >= sb) ? 1 : 0;
      13: return (a >= b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [13:0] onehot(int k);
    logic [13:0] one = 14'd1;
    return (k < 0 || k > 13) ? 14'd0 : (one << k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input int k,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      alu0 = onehot(k); a0 = a; b0 = b; v0 = 1'b1;
    end else begin
      alu1 = onehot(k); a1 = a; b1 = b; v1 = 1'b1;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 40);
      1: return 32'hFFFF_FFFF - $urandom_range(0, 5);
      default: return $urandom;
    endcase
  endfunction

  task automatic set_rand(input int n);
    set_req(n, $urandom_range(0, 14), rnd_operand(), rnd_operand());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    v0 = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_id", rsp_id, 0);
    check("rst_result", rsp_result, 0);
    check("rst_ready", {r0, r1}, 0);
    v0 = 1'b0;
    rst = 1'b0;
    exp_prio = 0;
  endtask

  // Serves one request from IDLE through the response handshake.
  task automatic run_one(input int hold);
    int w;
    logic [31:0] er;
    #1;
    if (v0 && v1) w = exp_prio;
    else if (v0) w = 0;
    else w = 1;
    er = (w == 0) ? ref_alu(alu0, a0, b0) : ref_alu(alu1, a1, b1);
    check("idle_busy", busy, 0);
    check("idle_rsp", rsp_valid, 0);
    check("rdy0", r0, v0 && w == 0);
    check("rdy1", r1, v1 && w == 1);
    @(posedge clk);
    @(negedge clk);
    if (w == 0) v0 = 1'b0;
    else v1 = 1'b0;
    #1;
    check("issue_busy", busy, 1);
    check("issue_rdy", {r0, r1}, 0);
    check("issue_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        #1;
      end
      check("done_valid", rsp_valid, 1);
      check("done_id", rsp_id, w);
      check("done_result", rsp_result, er);
      check("done_rdy", {r0, r1}, 0);
    end
    last_res = rsp_result;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("back_busy", busy, 0);
    check("back_rsp", rsp_valid, 0);
    exp_prio = (w == 0) ? 1 : 0;
  endtask

  initial begin
    int grants, rsps;

    do_reset();
    set_req(0, 0, 32'd5, 32'd7);
    run_one(0);
    check("t1_add", last_res, 32'd12);

    do_reset();
    set_req(0, 1, 32'd3, 32'd5);
    set_req(1, 4, 32'h0000_F0F0, 32'h0000_0FF0);
    run_one(0);
    check("t2_sub", last_res, 32'hFFFF_FFFE);
    set_req(0, 0, 32'd1, 32'd2);
    run_one(0);
    check("t2_xor", last_res, 32'h0000_FF00);
    for (int i = 0; i < 6; i++) begin
      if (!v0) set_rand(0);
      if (!v1) set_rand(1);
      run_one(0);
    end

    v0 = 1'b0; v1 = 1'b0;
    set_req(1, 9, 32'h8000_0000, 32'd4);
    run_one(3);
    check("t4_sra", last_res, 32'hF800_0000);

    set_req(0, 2, 32'hFFFF_FFFF, 32'd1);
    run_one(0);
    check("t5_slt", last_res, 32'd1);
    set_req(0, 13, 32'hFFFF_FFFF, 32'd1);
    run_one(0);
    check("t5_geu", last_res, 32'd1);
    set_req(0, 12, 32'hFFFF_FFFF, 32'd1);
    run_one(0);
    check("t5_ge", last_res, 32'd0);
    set_req(1, -1, 32'd9, 32'd9);
    run_one(1);
    check("zero_op", last_res, 32'd0);

    for (int i = 0; i < 40; i++) begin
      if (!v0 && ($urandom_range(0, 1) == 1)) set_rand(0);
      if (!v1 && ($urandom_range(0, 1) == 1)) set_rand(1);
      if (!v0 && !v1) set_rand($urandom_range(0, 1));
      run_one($urandom_range(0, 2));
    end

    v0 = 1'b0; v1 = 1'b0;
    set_req(0, 0, 32'd1, 32'd1);
    #1;
    check("t6_rdy", r0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_rst_valid", rsp_valid, 0);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    exp_prio = 0;
    @(negedge clk);
    #1;
    check("t6_no_rsp", rsp_valid, 0);
    check("t6_idle", busy, 0);
    set_req(0, 0, 32'd20, 32'd22);
    run_one(0);
    check("t6_after", last_res, 32'd42);

    rst = 1'b1;
    falu0 = onehot(0); fa0 = 32'd1; fb0 = 32'd2;
    falu1 = onehot(1); fa1 = 32'd9; fb1 = 32'd4;
    fv0 = 1'b1; fv1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grants = 0;
    rsps = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("fp_rdy1", fr1, 0);
      if (fr0) grants++;
      if (frsp_valid) begin
        rsps++;
        check("fp_id", frsp_id, 0);
        check("fp_result", frsp_result, 32'd3);
      end
      @(negedge clk);
    end
    check("fp_grants", grants, 3);
    check("fp_rsps", rsps, 3);
    fv0 = 1'b0; fv1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
